// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared FSM encoding and PC constants for the instruction fetch unit
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory read bus between fetch unit (master) and memory (slave)
interface ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_next_pc.sv
// rtl/ifetch_next_pc.sv - combinational next-pc select: jump > branch > sequential
module ifetch_next_pc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Word offset: the low two bits are implied zero, and the add wraps modulo 2^32.
    assign pc_plus4      = pc + PC_INC;
    assign branch_target = pc_plus4 + {branch_offset[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - request/wait/hold instruction fetch FSM with pc redirect
// Optional IFETCH_PERF_CNT_EN adds the fetch_count performance counter output.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    ifetch_if.master    imem,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [15:0] imm16
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    fetch_state_t state, state_nxt;
    logic         req_st;
    logic         load_pc;
    logic         capture;
    logic [31:0]  next_pc;

    ifetch_next_pc u_next_pc (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect inputs only matter through load_pc, which exists solely in S_HOLD without stall.
    always_comb begin
        state_nxt  = state;
        req_st     = 1'b0;
        inst_valid = 1'b0;
        load_pc    = 1'b0;
        capture    = 1'b0;
        case (state)
            S_REQ: begin
                req_st    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    load_pc   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_PC;
            inst <= 32'h0;
        end else begin
            if (load_pc) begin
                pc <= next_pc;
            end
            if (capture) begin
                inst <= imem.imem_rdata;
            end
        end
    end

    // The request is masked during reset so no fetch escapes in the reset cycle itself.
    assign imem.imem_req  = req_st & ~rst;
    assign imem.imem_addr = pc;
    assign imm16          = inst[15:0];

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'h0;
        end else if (load_pc) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - table-driven directed bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;

    logic        inst_valid1;
    logic [31:0] inst1;
    logic [31:0] pc1;
    logic [31:0] pc_plus41;
    logic [15:0] imm161;
    logic        rv1;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fc0;
    logic [31:0] fc1;
`endif

    int total;
    int bad;

    ifetch_if if0 ();
    ifetch_if if1 ();

    ifetch_unit dut0 (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem          (if0),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .imm16         (imm16)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count   (fc0)
`endif
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_offset (32'h0),
        .jump          (1'b0),
        .jump_index    (26'h0),
        .imem          (if1),
        .inst_valid    (inst_valid1),
        .inst          (inst1),
        .pc            (pc1),
        .pc_plus4      (pc_plus41),
        .imm16         (imm161)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count   (fc1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Second instance: memory answers one cycle after each request; log request addresses.
    always @(posedge clk) rv1 <= if1.imem_req;
    assign if1.imem_rvalid = rv1;
    assign if1.imem_rdata  = 32'h0;

    logic [31:0] q1[$];
    always @(negedge clk) begin
        if (if1.imem_req && q1.size() < 2) q1.push_back(if1.imem_addr);
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] boff;
        logic        jmp;
        logic [25:0] jidx;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] bo, logic j,
                                logic [25:0] ji, logic rv, logic [31:0] rd, logic eq,
                                logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.boff = bo; v.jmp = j; v.jidx = ji;
        v.rvalid = rv; v.rdata = rd; v.req = eq; v.addr = ea; v.valid = ev;
        v.inst = ei; v.pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
        jump = 1'b0; jump_index = 26'h0;
        if0.imem_rvalid = 1'b0; if0.imem_rdata = 32'h0;

        //             rst st br boff          jmp jidx     rv rdata          req addr          v  inst           pc
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          1, 32'h0,         0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'h2001_0005,  0, 32'h0,         0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h0,         1, 32'h2001_0005, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'hDEAD_BEEF,  1, 32'h4,         0, 32'h2001_0005, 32'h4));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h4,         0, 32'h2001_0005, 32'h4));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'h0800_0004,  0, 32'h4,         0, 32'h2001_0005, 32'h4));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 26'h4,   0, 32'h0,          0, 32'h4,         1, 32'h0800_0004, 32'h4));
        vecs.push_back(mk(0, 0, 1, 32'h8,         1, 26'h3,   0, 32'h0,          1, 32'h10,        0, 32'h0800_0004, 32'h10));
        vecs.push_back(mk(0, 0, 1, 32'h8,         1, 26'h3,   1, 32'h1000_FFFE,  0, 32'h10,        0, 32'h0800_0004, 32'h10));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFE, 0, 26'h0,   0, 32'h0,          0, 32'h10,        1, 32'h1000_FFFE, 32'h10));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          1, 32'hC,         0, 32'h1000_FFFE, 32'hC));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'h0,          0, 32'hC,         0, 32'h1000_FFFE, 32'hC));
        vecs.push_back(mk(0, 0, 1, 32'h0FFF_FFFC, 0, 26'h0,   0, 32'h0,          0, 32'hC,         1, 32'h0,         32'hC));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          1, 32'h4000_0000, 0, 32'h0,         32'h4000_0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'h0C00_0100,  0, 32'h4000_0000, 0, 32'h0,         32'h4000_0000));
        vecs.push_back(mk(0, 0, 1, 32'h10,        1, 26'h100, 0, 32'h0,          0, 32'h4000_0000, 1, 32'h0C00_0100, 32'h4000_0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          1, 32'h4000_0400, 0, 32'h0C00_0100, 32'h4000_0400));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'hAAAA_5555,  0, 32'h4000_0400, 0, 32'h0C00_0100, 32'h4000_0400));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h4000_0400, 1, 32'hAAAA_5555, 32'h4000_0400));
        vecs.push_back(mk(0, 1, 1, 32'h5,         0, 26'h0,   0, 32'h0,          0, 32'h4000_0400, 1, 32'hAAAA_5555, 32'h4000_0400));
        vecs.push_back(mk(0, 1, 1, 32'h5,         1, 26'h7,   0, 32'h0,          0, 32'h4000_0400, 1, 32'hAAAA_5555, 32'h4000_0400));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0,   1, 32'hBAD0_0001,  0, 32'h4000_0400, 1, 32'hAAAA_5555, 32'h4000_0400));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h4000_0400, 1, 32'hAAAA_5555, 32'h4000_0400));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h4000_0400, 1, 32'hAAAA_5555, 32'h4000_0400));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          1, 32'h4000_0404, 0, 32'hAAAA_5555, 32'h4000_0404));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h4000_0404, 0, 32'hAAAA_5555, 32'h4000_0404));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'hBAD0_BAD0,  1, 32'h0,         0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   1, 32'h1111_2222,  0, 32'h0,         0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,   0, 32'h0,          0, 32'h0,         1, 32'h1111_2222, 32'h0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            stall           = vecs[i].stall;
            branch_taken    = vecs[i].br;
            branch_offset   = vecs[i].boff;
            jump            = vecs[i].jmp;
            jump_index      = vecs[i].jidx;
            if0.imem_rvalid = vecs[i].rvalid;
            if0.imem_rdata  = vecs[i].rdata;
            #1;
            check("imem_req",   i, {31'h0, if0.imem_req}, {31'h0, vecs[i].req});
            check("imem_addr",  i, if0.imem_addr,         vecs[i].addr);
            check("inst_valid", i, {31'h0, inst_valid},   {31'h0, vecs[i].valid});
            check("inst",       i, inst,                  vecs[i].inst);
            check("pc",         i, pc,                    vecs[i].pc);
            check("pc_plus4",   i, pc_plus4,              vecs[i].pc + 32'd4);
            check("imm16",      i, {16'h0, imm16},        {16'h0, vecs[i].inst[15:0]});
        end

        @(negedge clk);
        stall = 1'b1;
        if0.imem_rvalid = 1'b0;
        #1;
        check("hold_to_req_addr", 99, if0.imem_addr, 32'h4);
`ifdef IFETCH_PERF_CNT_EN
        check("fetch_count", 99, fc0, 32'd1);
`endif

        check("wrap_fetch_count_seen", 100, q1.size(), 32'd2);
        if (q1.size() >= 2) begin
            check("wrap_first_addr",  100, q1[0], 32'hFFFF_FFFC);
            check("wrap_second_addr", 100, q1[1], 32'h0000_0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 stall  input  1  downstream not ready; holds current instruction.
REQ-005 branch_taken  input  1  redirect to branch target for held instruction.
REQ-006 branch_offset  input  32  sign-extended 16-bit offset, returned from the sign-extend stage.
REQ-007 jump  input  1  redirect to jump target for held instruction.
REQ-008 jump_index  input  26  jump instruction index field.
REQ-009 imem_req  output  1  instruction memory read request, one-cycle pulse.
REQ-010 imem_addr  output  32  read address, equals pc.
REQ-011 imem_rvalid  input  1  read data valid.
REQ-012 imem_rdata  input  32  read data.
REQ-013 inst_valid  output  1  inst/pc/imm16 valid.
REQ-014 inst  output  32  fetched instruction.
REQ-015 pc  output  32  address of inst.
REQ-016 pc_plus4  output  32  pc + 4.
REQ-017 imm16  output  16  inst[15:0], fed to the sign-extend stage.

Function
REQ-018 FSM SHALL have states S_REQ, S_WAIT, S_HOLD.
REQ-019 S_REQ: imem_req=1, imem_addr=pc; next state S_WAIT unconditionally.
REQ-020 S_WAIT: imem_req=0; on imem_rvalid capture imem_rdata into inst, go S_HOLD; else stay.
REQ-021 S_HOLD: inst_valid=1; if stall stay, inst/pc unchanged; else load next pc and go S_REQ.
REQ-022 Next pc priority: jump > branch_taken > pc_plus4.
REQ-023 Branch target = pc_plus4 + (branch_offset << 2), modulo 2^32.
REQ-024 Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
REQ-025 pc + 4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-026 branch_taken/jump SHALL be honoured only in S_HOLD with stall=0; ignored in all other cycles.
REQ-027 imem_rvalid outside S_WAIT SHALL be ignored.
REQ-028 Minimum latency: imem_req cycle N, imem_rvalid cycle N+1, inst_valid cycle N+2.
REQ-029 inst_valid SHALL be 0 in S_REQ and S_WAIT.
REQ-030 imm16 and pc_plus4 SHALL be combinational from inst and pc.

Reset
REQ-031 rst SHALL force state S_REQ, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0 in the reset cycle.
REQ-032 First cycle after rst deasserts SHALL issue imem_req with imem_addr=RESET_PC.
REQ-033 rst during S_WAIT SHALL abandon the fetch; a later imem_rvalid for it is ignored per REQ-027.

Configuration
REQ-034 Macro IFETCH_PERF_CNT_EN SHALL add output fetch_count (32 bits): increments on each S_HOLD->S_REQ transition, wraps at 2^32, reset to 0.
REQ-035 Without IFETCH_PERF_CNT_EN, fetch_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-036 Shared package ifetch_pkg SHALL hold the FSM state encoding, RESET_PC default and PC_INC=4 constant.
REQ-037 Sub-module ifetch_next_pc SHALL compute next pc (REQ-022..025) combinationally.

Verification
REQ-038 Reset then imem_rvalid one cycle after each request, rdata=32'h2001_0005 -> inst_valid at cycle 2, pc=0, imm16=16'h0005, next request addr 4.
REQ-039 In S_HOLD at pc=32'h0000_0010, branch_taken=1, branch_offset=32'hFFFF_FFFE -> next imem_addr=32'h0000_000C.
REQ-040 jump=1 and branch_taken=1 together at pc=32'h4000_0000, jump_index=26'h0000100 -> next imem_addr=32'h4000_0400.
REQ-041 stall=1 for 5 cycles in S_HOLD with branch_taken=1 pulsed during stall -> inst/pc constant, no imem_req, branch ignored, then pc+4 fetched.
REQ-042 RESET_PC=32'hFFFF_FFFC, no redirect -> second fetch addr 32'h0000_0000.
REQ-043 rst asserted in S_WAIT, stale imem_rvalid next cycle -> inst_valid stays 0, fetch restarts at RESET_PC.
